// File: rtl/led_phy_gs_shifter_pkg.sv
// Shared definitions for the LED PHY grayscale shifter: default geometry,
// FSM state encoding and a counter-width helper.
package led_phy_gs_shifter_pkg;

  localparam int DEF_DW       = 12;
  localparam int DEF_CHANNELS = 24;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_LAT_CYC  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } led_state_e;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_phy_bit_timer.sv
// Half-period timebase for the driver shift clock: tick marks the last cycle of
// each CLK_DIV-long half period, phase says which half (0 = sclk low).
module led_phy_bit_timer
  import led_phy_gs_shifter_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic phase
);

  localparam int DIVW = cnt_width(CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

  logic [DIVW-1:0] div_r;
  logic            phase_r;

  assign tick  = run & (div_r == DIV_LAST);
  assign phase = phase_r;

  // Divider and phase; parked at the start of a low phase whenever not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= '0;
      phase_r <= 1'b0;
    end else if (!run) begin
      div_r   <= '0;
      phase_r <= 1'b0;
    end else if (div_r == DIV_LAST) begin
      div_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      div_r   <= div_r + 1'b1;
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/led_phy_gs_shifter.sv
// Pops grayscale words from a show-ahead FIFO and shifts them MSB-first onto a
// sclk/sdi/lat LED driver bus, latching once every CHANNELS words.
module led_phy_gs_shifter
  import led_phy_gs_shifter_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int LAT_CYC  = DEF_LAT_CYC
) (
  input  logic          clkr,
  input  logic          rst,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_valid,
  output logic          fifo_re,
  output logic          sclk,
  output logic          sdi,
  output logic          lat,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int BITW = cnt_width(DW);
  localparam int WCW  = cnt_width(CHANNELS + 1);
  localparam int LATW = cnt_width(LAT_CYC);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(DW - 1);
  localparam logic [WCW-1:0]  WORD_LAST = WCW'(CHANNELS - 1);
  localparam logic [LATW-1:0] LAT_LAST  = LATW'(LAT_CYC - 1);

  led_state_e      state_r;
  logic [DW-1:0]   shreg_r;
  logic [BITW-1:0] bit_cnt_r;
  logic [WCW-1:0]  word_cnt_r;
  logic [LATW-1:0] lat_cnt_r;
  logic            sclk_r;
  logic            sdi_r;
  logic            lat_r;
  logic            busy_r;
  logic            frame_done_r;
  logic            underrun_r;

  logic            run_s;
  logic            tick_s;
  logic            phase_s;
  logic            bit_end_s;
  logic            word_end_s;
  logic            last_word_s;
  logic            pop_s;
  logic [DW-1:0]   shreg_next_s;

  assign run_s        = (state_r == ST_SHIFT);
  assign bit_end_s    = tick_s & phase_s;
  assign word_end_s   = bit_end_s & (bit_cnt_r == BIT_LAST);
  assign last_word_s  = (word_cnt_r == WORD_LAST);
  assign shreg_next_s = shreg_r << 1;

  led_phy_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk   (clkr),
    .rst   (rst),
    .run   (run_s),
    .tick  (tick_s),
    .phase (phase_s)
  );

  // Pop strobe: from IDLE, or back-to-back at a word end that does not close the frame.
  always_comb begin
    pop_s = 1'b0;
    if (rst) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  pop_s = fifo_valid;
        ST_SHIFT: pop_s = fifo_valid & word_end_s & ~last_word_s;
        default:  pop_s = 1'b0;
      endcase
    end
  end

  assign fifo_re = pop_s;

  // Frame FSM, shift register, counters and all registered driver outputs.
  always_ff @(posedge clkr) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      word_cnt_r   <= '0;
      lat_cnt_r    <= '0;
      sclk_r       <= 1'b0;
      sdi_r        <= 1'b0;
      lat_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk_r <= 1'b0;
          lat_r  <= 1'b0;
          // A partially shifted frame keeps busy high while stalled here.
          busy_r <= pop_s | (word_cnt_r != '0);
          if (pop_s) begin
            shreg_r   <= fifo_dout;
            sdi_r     <= fifo_dout[DW-1];
            bit_cnt_r <= '0;
            state_r   <= ST_SHIFT;
          end else begin
            state_r   <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          busy_r <= 1'b1;
          if (word_end_s) begin
            sclk_r    <= 1'b0;
            bit_cnt_r <= '0;
            if (last_word_s) begin
              lat_r     <= 1'b1;
              lat_cnt_r <= '0;
              state_r   <= ST_LATCH;
            end else begin
              word_cnt_r <= word_cnt_r + 1'b1;
              if (pop_s) begin
                shreg_r <= fifo_dout;
                sdi_r   <= fifo_dout[DW-1];
                state_r <= ST_SHIFT;
              end else begin
                underrun_r <= 1'b1;
                state_r    <= ST_IDLE;
              end
            end
          end else if (bit_end_s) begin
            // sdi only moves at the start of a low phase, so it is stable at the rise.
            sclk_r    <= 1'b0;
            shreg_r   <= shreg_next_s;
            sdi_r     <= shreg_next_s[DW-1];
            bit_cnt_r <= bit_cnt_r + 1'b1;
          end else if (tick_s) begin
            sclk_r <= 1'b1;
          end else begin
            sclk_r <= sclk_r;
          end
        end

        ST_LATCH: begin
          sclk_r <= 1'b0;
          if (lat_cnt_r == LAT_LAST) begin
            lat_r        <= 1'b0;
            frame_done_r <= 1'b1;
            word_cnt_r   <= '0;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r + 1'b1;
            busy_r    <= 1'b1;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          sclk_r     <= 1'b0;
          lat_r      <= 1'b0;
          busy_r     <= 1'b0;
          word_cnt_r <= '0;
        end
      endcase
    end
  end

  assign sclk       = sclk_r;
  assign sdi        = sdi_r;
  assign lat        = lat_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_led_phy_gs_shifter.sv
// Scoreboard bench: lane A (2 channels, CLK_DIV=1) and lane B (24 channels, CLK_DIV=2)
// each fed by a show-ahead FIFO model; expected sdi bits are queued at push time.
module tb_led_phy_gs_shifter;

  localparam int DW   = 12;
  localparam int CH_A = 2;
  localparam int DV_A = 1;
  localparam int CH_B = 24;
  localparam int DV_B = 2;
  localparam int LATC = 2;
  localparam int WP_A = 2 * DW * DV_A;
  localparam int WP_B = 2 * DW * DV_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- lane A ----------------
  logic          rst_a = 1'b1;
  logic          fv_a  = 1'b0;
  logic [DW-1:0] fd_a  = '0;
  logic re_a, sclk_a, sdi_a, lat_a, busy_a, fdone_a, und_a;
  logic [DW-1:0] fq_a[$];
  bit            exp_a[$];

  led_phy_gs_shifter #(.DW(DW), .CHANNELS(CH_A), .CLK_DIV(DV_A), .LAT_CYC(LATC)) dut_a (
    .clkr(clk), .rst(rst_a), .fifo_dout(fd_a), .fifo_valid(fv_a), .fifo_re(re_a),
    .sclk(sclk_a), .sdi(sdi_a), .lat(lat_a), .busy(busy_a),
    .frame_done(fdone_a), .underrun(und_a)
  );

  initial begin : fifo_model_a
    bit pop;
    forever begin
      @(negedge clk);
      pop = re_a;
      @(posedge clk);
      #1;
      if (pop && fq_a.size() > 0) void'(fq_a.pop_front());
      fv_a = (fq_a.size() > 0);
      fd_a = fv_a ? fq_a[0] : '0;
    end
  end

  int rises_a = 0, pops_a = 0, pif_a = 0, gap_a = 0, lat_len_a = 0, frames_a = 0, und_cnt_a = 0;
  logic sclk_pa = 1'b0, sdi_pa = 1'b0, lat_pa = 1'b0;
  bit stall_a = 1'b0;

  always @(negedge clk) begin
    sclk_pa <= sclk_a;
    sdi_pa  <= sdi_a;
    lat_pa  <= lat_a;
    if (rst_a) begin
      rises_a   <= 0;
      pif_a     <= 0;
      gap_a     <= 0;
      lat_len_a <= 0;
      stall_a   <= 1'b0;
    end else begin
      check_eq("lat_sclk_a", 32'(lat_a & sclk_a), 32'd0);
      check_eq("frame_done_a", 32'(fdone_a), 32'(lat_pa & ~lat_a));
      if (re_a) begin
        check_eq("re_valid_a", 32'(fv_a), 32'd1);
        if (pif_a > 0 && !stall_a) check_eq("word_gap_a", gap_a, WP_A);
        pif_a   <= pif_a + 1;
        pops_a  <= pops_a + 1;
        gap_a   <= 1;
        stall_a <= 1'b0;
      end else begin
        gap_a <= gap_a + 1;
      end
      if (und_a) begin
        stall_a   <= 1'b1;
        und_cnt_a <= und_cnt_a + 1;
      end
      if (sclk_a && !sclk_pa) begin
        check_eq("sdi_stable_a", 32'(sdi_a), 32'(sdi_pa));
        check_eq("sdi_a", (exp_a.size() == 0 ? 32'h100 : 32'h0) | 32'(sdi_a),
                 32'(exp_a.size() > 0 ? exp_a[0] : 1'b0));
        if (exp_a.size() > 0) void'(exp_a.pop_front());
        rises_a <= rises_a + 1;
      end
      if (lat_a && !lat_pa) begin
        check_eq("bits_per_frame_a", rises_a, CH_A * DW);
        rises_a <= 0;
        pif_a   <= 0;
      end
      if (lat_a) lat_len_a <= lat_len_a + 1;
      else if (lat_pa) begin
        check_eq("lat_len_a", lat_len_a, LATC);
        lat_len_a <= 0;
      end
      if (fdone_a) frames_a <= frames_a + 1;
    end
  end

  // ---------------- lane B ----------------
  logic          rst_b = 1'b1;
  logic          fv_b  = 1'b0;
  logic [DW-1:0] fd_b  = '0;
  logic re_b, sclk_b, sdi_b, lat_b, busy_b, fdone_b, und_b;
  logic [DW-1:0] fq_b[$];
  bit            exp_b[$];

  led_phy_gs_shifter #(.DW(DW), .CHANNELS(CH_B), .CLK_DIV(DV_B), .LAT_CYC(LATC)) dut_b (
    .clkr(clk), .rst(rst_b), .fifo_dout(fd_b), .fifo_valid(fv_b), .fifo_re(re_b),
    .sclk(sclk_b), .sdi(sdi_b), .lat(lat_b), .busy(busy_b),
    .frame_done(fdone_b), .underrun(und_b)
  );

  initial begin : fifo_model_b
    bit pop;
    forever begin
      @(negedge clk);
      pop = re_b;
      @(posedge clk);
      #1;
      if (pop && fq_b.size() > 0) void'(fq_b.pop_front());
      fv_b = (fq_b.size() > 0);
      fd_b = fv_b ? fq_b[0] : '0;
    end
  end

  int rises_b = 0, pops_b = 0, pif_b = 0, gap_b = 0, lat_len_b = 0, frames_b = 0, und_cnt_b = 0;
  logic sclk_pb = 1'b0, sdi_pb = 1'b0, lat_pb = 1'b0;
  bit stall_b = 1'b0;

  always @(negedge clk) begin
    sclk_pb <= sclk_b;
    sdi_pb  <= sdi_b;
    lat_pb  <= lat_b;
    if (rst_b) begin
      rises_b   <= 0;
      pif_b     <= 0;
      gap_b     <= 0;
      lat_len_b <= 0;
      stall_b   <= 1'b0;
    end else begin
      check_eq("lat_sclk_b", 32'(lat_b & sclk_b), 32'd0);
      check_eq("frame_done_b", 32'(fdone_b), 32'(lat_pb & ~lat_b));
      if (re_b) begin
        check_eq("re_valid_b", 32'(fv_b), 32'd1);
        if (pif_b > 0 && !stall_b) check_eq("word_gap_b", gap_b, WP_B);
        pif_b   <= pif_b + 1;
        pops_b  <= pops_b + 1;
        gap_b   <= 1;
        stall_b <= 1'b0;
      end else begin
        gap_b <= gap_b + 1;
      end
      if (und_b) begin
        stall_b   <= 1'b1;
        und_cnt_b <= und_cnt_b + 1;
      end
      if (sclk_b && !sclk_pb) begin
        check_eq("sdi_stable_b", 32'(sdi_b), 32'(sdi_pb));
        check_eq("sdi_b", (exp_b.size() == 0 ? 32'h100 : 32'h0) | 32'(sdi_b),
                 32'(exp_b.size() > 0 ? exp_b[0] : 1'b0));
        if (exp_b.size() > 0) void'(exp_b.pop_front());
        rises_b <= rises_b + 1;
      end
      if (lat_b && !lat_pb) begin
        check_eq("bits_per_frame_b", rises_b, CH_B * DW);
        rises_b <= 0;
        pif_b   <= 0;
      end
      if (lat_b) lat_len_b <= lat_len_b + 1;
      else if (lat_pb) begin
        check_eq("lat_len_b", lat_len_b, LATC);
        lat_len_b <= 0;
      end
      if (fdone_b) frames_b <= frames_b + 1;
    end
  end

  task automatic push_a(input logic [DW-1:0] w);
    fq_a.push_back(w);
    for (int i = DW - 1; i >= 0; i--) exp_a.push_back(w[i]);
  endtask

  task automatic push_b(input logic [DW-1:0] w);
    fq_b.push_back(w);
    for (int i = DW - 1; i >= 0; i--) exp_b.push_back(w[i]);
  endtask

  task automatic push_rand_b(input int n);
    for (int i = 0; i < n; i++) push_b(DW'($urandom_range(0, (1 << DW) - 1)));
  endtask

  initial begin
    // reset held with lane A's FIFO already non-empty
    push_a(12'hA5C);
    push_a(12'h3F0);
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_outs_a", {25'd0, sclk_a, sdi_a, lat_a, busy_a, fdone_a, und_a, re_a}, 32'd0);
      check_eq("reset_outs_b", {25'd0, sclk_b, sdi_b, lat_b, busy_b, fdone_b, und_b, re_b}, 32'd0);
    end
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // single two-word frame on lane A
    for (int i = 0; i < 400 && frames_a < 1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("frames_a", frames_a, 32'd1);
    check_eq("pops_a", pops_a, 32'd2);
    check_eq("sb_left_a", exp_a.size(), 32'd0);
    check_eq("busy_idle_a", 32'(busy_a), 32'd0);
    check_eq("underrun_a", und_cnt_a, 32'd0);

    // three back-to-back frames on lane B
    push_rand_b(3 * CH_B);
    for (int i = 0; i < 6000 && frames_b < 3; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("frames_b3", frames_b, 32'd3);
    check_eq("pops_b3", pops_b, 32'd72);
    check_eq("sb_left_b3", exp_b.size(), 32'd0);
    check_eq("busy_idle_b3", 32'(busy_b), 32'd0);
    check_eq("no_underrun_b3", und_cnt_b, 32'd0);

    // underrun after word 5, refill 50 cycles later
    push_rand_b(5);
    for (int i = 0; i < 600 && und_cnt_b < 1; i++) @(negedge clk);
    @(negedge clk);
    check_eq("underrun_seen", und_cnt_b, 32'd1);
    check_eq("stall_sclk", 32'(sclk_b), 32'd0);
    check_eq("stall_busy", 32'(busy_b), 32'd1);
    repeat (50) @(negedge clk);
    check_eq("underrun_once", und_cnt_b, 32'd1);
    check_eq("no_early_latch", frames_b, 32'd3);
    check_eq("stall_busy_late", 32'(busy_b), 32'd1);
    push_rand_b(CH_B - 5);
    for (int i = 0; i < 2000 && frames_b < 4; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("frames_b4", frames_b, 32'd4);
    check_eq("pops_b4", pops_b, 32'd96);
    check_eq("sb_left_b4", exp_b.size(), 32'd0);
    check_eq("underrun_total", und_cnt_b, 32'd1);

    // reset during bit 7 of word 3, then a fresh full frame
    push_rand_b(CH_B);
    for (int i = 0; i < 2000 && rises_b < 31; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    fq_b.delete();
    exp_b.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_outs_b", {25'd0, sclk_b, sdi_b, lat_b, busy_b, fdone_b, und_b, re_b}, 32'd0);
    check_eq("midrst_no_latch", frames_b, 32'd4);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    push_rand_b(CH_B);
    for (int i = 0; i < 2000 && frames_b < 5; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("frames_b5", frames_b, 32'd5);
    check_eq("sb_left_b5", exp_b.size(), 32'd0);
    check_eq("busy_idle_b5", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
